code_hist: RTL and testbench

- Histogram accumulator directly downstream of the ADC sample FIFO in the code-density design.
- Each 10-bit ADC code accepted over a valid/ready handshake increments a 16-bit bin in an internal RAM (1024 x 16) by read-modify-write.
- On a dump request it streams every bin, MSB byte first, to the serial (UART) transmitter over a byte handshake.

---
 rtl/code_hist.sv | 147 ++++++++++++++
 tb/tb_code_hist.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/code_hist.sv
// Code-density histogram: 1024 x 16 bin RAM updated by saturating read-modify-write,
// streamed MSB-first over a byte handshake on dump. CODE_HIST_DUMP_CLEAR_EN makes dump clear-on-read.
module code_hist #(
  parameter int unsigned CODE_W = 10,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] code_data,
  input  logic              code_valid,
  output logic              code_ready,
  input  logic              clear,
  input  logic              dump,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              sat
);

  localparam int unsigned       DEPTH     = 1 << CODE_W;
  localparam logic [CODE_W-1:0] LAST_ADDR = CODE_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [2:0] {
    S_CLR, S_IDLE, S_A_RD, S_A_WR, S_D_RD, S_D_HI, S_D_LO
  } state_t;

  state_t            state_q, state_d;
  logic [CODE_W-1:0] clr_addr_q, clr_addr_d;
  logic [CODE_W-1:0] d_addr_q, d_addr_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              sat_q, sat_d;

  logic [CNT_W-1:0]  mem_q [DEPTH];
  logic [CNT_W-1:0]  rd_q;

  logic              we_c, re_c;
  logic [CODE_W-1:0] wr_addr_c, rd_addr_c;
  logic [CNT_W-1:0]  wr_data_c, inc_c;

  // Control state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_CLR;
      clr_addr_q <= '0;
      d_addr_q   <= '0;
      code_q     <= '0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      d_addr_q   <= d_addr_d;
      code_q     <= code_d;
      sat_q      <= sat_d;
    end
  end

  // Single-port bin RAM with registered read data
  always_ff @(posedge clk) begin
    if (we_c && rst) mem_q[wr_addr_c] <= wr_data_c;
    if (re_c)        rd_q <= mem_q[rd_addr_c];
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    d_addr_d   = d_addr_q;
    code_d     = code_q;
    sat_d      = sat_q;
    we_c       = 1'b0;
    re_c       = 1'b0;
    wr_addr_c  = clr_addr_q;
    wr_data_c  = '0;
    rd_addr_c  = code_q;
    inc_c      = (rd_q == CNT_MAX) ? CNT_MAX : rd_q + CNT_W'(1);

    case (state_q)
      S_CLR: begin
        we_c       = 1'b1;
        sat_d      = 1'b0;
        clr_addr_d = clr_addr_q + CODE_W'(1);
        if (clr_addr_q == LAST_ADDR) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (clear) begin
          state_d    = S_CLR;
          clr_addr_d = '0;
          sat_d      = 1'b0;
        end else if (dump) begin
          state_d  = S_D_RD;
          d_addr_d = '0;
        end else if (code_valid) begin
          code_d  = code_data;
          state_d = S_A_RD;
        end
      end
      S_A_RD: begin
        re_c    = 1'b1;
        state_d = S_A_WR;
      end
      S_A_WR: begin
        we_c      = 1'b1;
        wr_addr_c = code_q;
        wr_data_c = inc_c;
        if (inc_c == CNT_MAX) sat_d = 1'b1;
        state_d   = S_IDLE;
      end
      S_D_RD: begin
        re_c      = 1'b1;
        rd_addr_c = d_addr_q;
        state_d   = S_D_HI;
      end
      S_D_HI: begin
        if (tx_ready) state_d = S_D_LO;
      end
      S_D_LO: begin
        if (tx_ready) begin
`ifdef CODE_HIST_DUMP_CLEAR_EN
          we_c      = 1'b1;
          wr_addr_c = d_addr_q;
          wr_data_c = '0;
`endif
          if (d_addr_q == LAST_ADDR) begin
            state_d = S_IDLE;
`ifdef CODE_HIST_DUMP_CLEAR_EN
            sat_d   = 1'b0;
`endif
          end else begin
            d_addr_d = d_addr_q + CODE_W'(1);
            state_d  = S_D_RD;
          end
        end
      end
      default: state_d = S_CLR;
    endcase
  end

  // Outputs decode registered state; tx_data holds while a byte waits for acceptance
  assign code_ready = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign tx_valid   = (state_q == S_D_HI) || (state_q == S_D_LO);
  assign tx_data    = (state_q == S_D_HI) ? rd_q[CNT_W-1 -: 8] :
                      (state_q == S_D_LO) ? rd_q[7:0] : 8'h00;
  assign sat        = sat_q;

endmodule

// File: tb/tb_code_hist.sv
// Scoreboard bench for code_hist: driver pushes expected dump bytes, a negedge monitor pops and compares.
module tb_code_hist;

  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned NBYTES = 2048;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] code_data;
  logic       code_valid, code_ready, clear, dump;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready, busy, sat;

  always #5 clk = ~clk;

  code_hist dut (
    .clk(clk), .rst(rst), .code_data(code_data), .code_valid(code_valid),
    .code_ready(code_ready), .clear(clear), .dump(dump), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .sat(sat)
  );

  int         n_cmp = 0;
  int         n_fail = 0;
  int         rx_cnt = 0;
  int         rx_base = 0;
  int         acc_cnt = 0;
  int         cyc = 0;
  int         stall_left = 0;
  bit         stall_en = 1'b0;
  logic [7:0] exp_q [$];
  logic [9:0] feed_q [$];
  logic [15:0] exp_bin [DEPTH];
  bit         prev_hold = 1'b0;
  logic       prev_rst = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // tx_ready driver: random 50-cycle stalls when enabled
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_left > 0) begin
        tx_ready = 1'b0;
        stall_left--;
      end else begin
        tx_ready = 1'b1;
        if (stall_en && $urandom_range(0, 63) == 0) stall_left = 50;
      end
    end
  end

  // Monitor: byte scoreboard, hold-stability, and code acceptance count
  always @(negedge clk) begin
    logic [7:0] b;
    if (prev_hold && prev_rst) begin
      check("tx_valid_hold", 32'(tx_valid), 32'd1);
      check("tx_data_hold", 32'(tx_data), 32'(prev_data));
    end
    if (tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_byte: got 0x%0h, required no byte", tx_data);
      end else begin
        b = exp_q.pop_front();
        check($sformatf("byte[%0d]", rx_cnt - rx_base), 32'(tx_data), 32'(b));
      end
      rx_cnt++;
    end
    prev_hold = tx_valid && !tx_ready;
    prev_data = tx_data;
    prev_rst  = rst;
    if (code_valid && code_ready && !dump && !clear) acc_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle;
    int n = 0;
    while (busy && n < 5000) begin tick(); n++; end
    check("idle_reached", 32'(busy), 32'd0);
  endtask

  task automatic count_clr;
    int n = 0;
    while (busy && n < 5000) begin tick(); n++; end
    check("clr_cycles", 32'(n), 32'd1024);
    check("idle_code_ready", 32'(code_ready), 32'd1);
  endtask

  task automatic feed_seq(input bit chk_gap);
    int last = -1;
    int n;
    bit hs;
    wait_idle();
    code_valid = 1'b1;
    foreach (feed_q[i]) begin
      code_data = feed_q[i];
      n = 0;
      do begin
        @(negedge clk);
        hs = code_ready;
        tick();
        n++;
      end while (!hs && n < 100);
      check($sformatf("code_accept[%0d]", i), 32'(hs), 32'd1);
      if (chk_gap && last >= 0) check("code_gap", 32'(cyc - last), 32'd3);
      last = cyc;
    end
    code_valid = 1'b0;
    feed_q.delete();
  endtask

  task automatic start_dump;
    wait_idle();
    for (int a = 0; a < int'(DEPTH); a++) begin
      exp_q.push_back(exp_bin[a][15:8]);
      exp_q.push_back(exp_bin[a][7:0]);
    end
    rx_base = rx_cnt;
    dump = 1'b1;
    tick();
    dump = 1'b0;
  endtask

  task automatic finish_dump;
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 40000) begin tick(); n++; end
    check("dump_drained", 32'(exp_q.size()), 32'd0);
    check("dump_len", 32'(rx_cnt - rx_base), 32'(NBYTES));
    exp_q.delete();
`ifdef CODE_HIST_DUMP_CLEAR_EN
    for (int a = 0; a < int'(DEPTH); a++) exp_bin[a] = 16'h0000;
`endif
  endtask

  task automatic zero_exp;
    for (int a = 0; a < int'(DEPTH); a++) exp_bin[a] = 16'h0000;
  endtask

  initial begin
    int snap;
    int n;
    bit hs;
    rst = 1'b0; code_valid = 1'b0; code_data = '0; clear = 1'b0; dump = 1'b0;
    zero_exp();

    // Reset state, then CLR sweep length
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_code_ready", 32'(code_ready), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_sat", 32'(sat), 32'd0);
    rst = 1'b1;
    count_clr();
    start_dump(); finish_dump();

    // Accumulate 5,5,5,1023,0 back-to-back
    feed_q = '{10'd5, 10'd5, 10'd5, 10'd1023, 10'd0};
    feed_seq(1'b1);
    exp_bin[5] = 16'd3; exp_bin[1023] = 16'd1; exp_bin[0] = 16'd1;
    start_dump(); finish_dump();

    // Saturation: preload bin 7 near full, then step through 0xFFFF
    wait_idle();
    dut.mem_q[7] = 16'hFFFD;
    feed_q = '{10'd7}; feed_seq(1'b0); wait_idle();
    check("sat_at_fffe", 32'(sat), 32'd0);
    feed_q = '{10'd7}; feed_seq(1'b0); wait_idle();
    check("sat_at_ffff", 32'(sat), 32'd1);
    feed_q = '{10'd7}; feed_seq(1'b0); wait_idle();
    check("sat_sticky", 32'(sat), 32'd1);
    exp_bin[7] = 16'hFFFF;
    start_dump(); finish_dump();
`ifdef CODE_HIST_DUMP_CLEAR_EN
    check("sat_after_dump", 32'(sat), 32'd0);
`else
    check("sat_after_dump", 32'(sat), 32'd1);
`endif
    clear = 1'b1; tick(); clear = 1'b0;
    check("clear_sat", 32'(sat), 32'd0);
    check("clear_busy", 32'(busy), 32'd1);
    count_clr();
    zero_exp();
    start_dump(); finish_dump();

    // Backpressure: same accumulation, dump under random stalls
    feed_q = '{10'd5, 10'd5, 10'd5, 10'd1023, 10'd0};
    feed_seq(1'b1);
    exp_bin[5] = 16'd3; exp_bin[1023] = 16'd1; exp_bin[0] = 16'd1;
    stall_en = 1'b1;
    start_dump(); finish_dump();
    stall_en = 1'b0;

    // Dump beats a simultaneous code; code is taken after the dump
    wait_idle();
    snap = acc_cnt;
    code_data = 10'd9;
    code_valid = 1'b1;
    start_dump(); finish_dump();
    check("prio_no_accept", 32'(acc_cnt), 32'(snap));
    n = 0;
    do begin
      @(negedge clk);
      hs = code_ready;
      tick();
      n++;
    end while (!hs && n < 100);
    code_valid = 1'b0;
    check("prio_accept_after", 32'(acc_cnt), 32'(snap + 1));
    exp_bin[9] = exp_bin[9] + 16'd1;
    wait_idle();

    // Reset in the middle of a dump (around address 300)
    start_dump();
    n = 0;
    while ((rx_cnt - rx_base) < 600 && n < 20000) begin tick(); n++; end
    check("mid_dump_reached", 32'(rx_cnt - rx_base >= 600), 32'd1);
    rst = 1'b0;
    tick();
    check("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd1);
    check("mid_rst_code_ready", 32'(code_ready), 32'd0);
    rst = 1'b1;
    exp_q.delete();
    count_clr();
    check("mid_rst_sat", 32'(sat), 32'd0);
    zero_exp();
    start_dump(); finish_dump();

    // Two dumps of bin 3 = 2: repeat (non-destructive) or zero (clear-on-read)
    feed_q = '{10'd3, 10'd3};
    feed_seq(1'b1);
    exp_bin[3] = 16'd2;
    start_dump(); finish_dump();
    start_dump(); finish_dump();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
